folded_maj_sched: RTL and testbench

//  Time-multiplexed (folded) majority/threshold evaluator controller. Accepts one N-bit vector per

---
 rtl/folded_maj_sched.sv | 174 +++++++++++++++++
 tb/tb_folded_maj_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/folded_maj_sched.sv
// folded_maj_sched
//   Folded majority / threshold evaluator. One N-bit vector is accepted per
//   transaction and streamed CHUNK bits per cycle through a single popcount
//   slice. A running count is compared against THRESH. With EARLY_EXIT set,
//   evaluation stops as soon as the outcome can no longer change.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset (discards any vector in flight)
//   in_valid   in   1   in_x is valid
//   in_ready   out  1   block can accept a vector (high only while idle)
//   in_x       in   N   input vector, bit i = majority input x_i
//   out_valid  out  1   result valid, held until out_ready
//   out_ready  in   1   consumer accepts the result
//   out_y      out  1   1 iff popcount(x) >= THRESH
//   out_early  out  1   result was decided before the last chunk
//   out_chunks out  KW  number of chunks consumed (1..NCHUNK)
module folded_maj_sched #(
  parameter int N          = 13,
  parameter int CHUNK      = 4,
  parameter int THRESH     = (N + 1) / 2,
  parameter int EARLY_EXIT = 1,
  // Guarded so an illegal CHUNK reaches the parameter check below instead of a divide by zero.
  localparam int NCHUNK    = (CHUNK < 1) ? 1 : (N + CHUNK - 1) / CHUNK,
  localparam int CW        = $clog2(N + 1),
  localparam int KW        = $clog2(NCHUNK + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_y,
  output logic          out_early,
  output logic [KW-1:0] out_chunks
);

  generate
    if (CHUNK < 1 || CHUNK > N) begin : g_bad_chunk
      $fatal(1, "folded_maj_sched: CHUNK=%0d outside 1..N=%0d", CHUNK, N);
    end
    if (THRESH < 1 || THRESH > N) begin : g_bad_thresh
      $fatal(1, "folded_maj_sched: THRESH=%0d outside 1..N=%0d", THRESH, N);
    end
  endgenerate

  // Vector storage is padded to a whole number of chunks; pad bits stay 0 so a
  // partial last chunk counts only real inputs.
  localparam int PADW = NCHUNK * CHUNK;

  localparam logic [KW-1:0] LAST_IDX = KW'(NCHUNK - 1);
  localparam logic [CW:0]   THR      = (CW + 1)'(THRESH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_reg,  state_next;
  logic [PADW-1:0] vec_reg,    vec_next;
  logic [CW-1:0]   count_reg,  count_next;
  logic [KW-1:0]   idx_reg,    idx_next;
  logic            y_reg,      y_next;
  logic            early_reg,  early_next;
  logic [KW-1:0]   chunks_reg, chunks_next;

  // Shared datapath: popcount of the current chunk and decision terms.
  logic [CHUNK-1:0] slice;
  logic [CW-1:0]    pc;
  logic [CW-1:0]    nc;
  logic [CW-1:0]    rem;
  logic             last_chunk;
  logic             reached;
  logic             unreachable;
  logic             decide;

  assign slice = vec_reg[int'(idx_reg) * CHUNK +: CHUNK];

  always_comb begin
    pc = '0;
    for (int i = 0; i < CHUNK; i++) begin
      pc = pc + CW'(slice[i]);
    end
  end

  // Inputs still unseen after this chunk: N - min(N, (idx+1)*CHUNK).
  always_comb begin
    int covered;
    covered = (int'(idx_reg) + 1) * CHUNK;
    if (covered > N) begin
      covered = N;
    end
    rem = CW'(N - covered);
  end

  assign nc          = count_reg + pc;
  assign last_chunk  = (idx_reg == LAST_IDX);
  assign reached     = ({1'b0, nc} >= THR);
  // Even if every remaining input were 1 the threshold could not be met.
  assign unreachable = (({1'b0, nc} + {1'b0, rem}) < THR);
  assign decide      = last_chunk | ((EARLY_EXIT != 0) & (reached | unreachable));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      vec_reg    <= '0;
      count_reg  <= '0;
      idx_reg    <= '0;
      y_reg      <= 1'b0;
      early_reg  <= 1'b0;
      chunks_reg <= '0;
    end else begin
      state_reg  <= state_next;
      vec_reg    <= vec_next;
      count_reg  <= count_next;
      idx_reg    <= idx_next;
      y_reg      <= y_next;
      early_reg  <= early_next;
      chunks_reg <= chunks_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    vec_next    = vec_reg;
    count_next  = count_reg;
    idx_next    = idx_reg;
    y_next      = y_reg;
    early_next  = early_reg;
    chunks_next = chunks_reg;

    unique case (state_reg)
      IDLE: begin
        if (in_valid) begin
          vec_next         = '0;
          vec_next[N-1:0]  = in_x;
          count_next       = '0;
          idx_next         = '0;
          state_next       = ACCUM;
        end
      end
      ACCUM: begin
        if (decide) begin
          y_next      = reached;
          early_next  = ~last_chunk;
          chunks_next = idx_reg + KW'(1);
          state_next  = DONE;
        end else begin
          count_next = nc;
          idx_next   = idx_reg + KW'(1);
        end
      end
      DONE: begin
        // No bypass: in_ready only returns once the state is back in IDLE.
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign out_y      = y_reg;
  assign out_early  = early_reg;
  assign out_chunks = chunks_reg;

endmodule

// File: tb/tb_folded_maj_sched.sv
// Bench for folded_maj_sched: four instances with different THRESH / EARLY_EXIT
// settings, driven by directed steps plus random vectors, each result checked
// against a prefix-count reference model.
module tb_folded_maj_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] in_x;
  logic        in_valid   [4];
  logic        out_ready  [4];
  logic        in_ready   [4];
  logic        out_valid  [4];
  logic        out_y      [4];
  logic        out_early  [4];
  logic [2:0]  out_chunks [4];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int thr_of [4] = '{7, 7, 1, 13};
  int ee_of  [4] = '{1, 0, 1, 1};

  always #5 clk = ~clk;

  folded_maj_sched #(.EARLY_EXIT(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_x(in_x),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_y(out_y[0]),
    .out_early(out_early[0]), .out_chunks(out_chunks[0]));

  folded_maj_sched #(.EARLY_EXIT(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_x(in_x),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_y(out_y[1]),
    .out_early(out_early[1]), .out_chunks(out_chunks[1]));

  folded_maj_sched #(.THRESH(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_x(in_x),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_y(out_y[2]),
    .out_early(out_early[2]), .out_chunks(out_chunks[2]));

  folded_maj_sched #(.THRESH(13)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_x(in_x),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_y(out_y[3]),
    .out_early(out_early[3]), .out_chunks(out_chunks[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: y from the total popcount; chunks = first k whose prefix of
  // min(13,4k) inputs already fixes the outcome (or 4 without early exit).
  function automatic void model(input int thr, input int ee, input logic [12:0] x,
                                output int y, output int early, output int chunks);
    int tot;
    tot    = $countones(x);
    y      = (tot >= thr) ? 1 : 0;
    chunks = 4;
    for (int k = 1; k <= 3; k++) begin
      int cov;
      int pre;
      cov = (4 * k > 13) ? 13 : 4 * k;
      pre = $countones(int'(x) & ((1 << cov) - 1));
      if (ee != 0 && (pre >= thr || pre + (13 - cov) < thr)) begin
        chunks = k;
        break;
      end
    end
    early = (chunks < 4) ? 1 : 0;
  endfunction

  task automatic wait_ready(input int u);
    int w;
    w = 0;
    while (in_ready[u] !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check("in_ready_wait", 32'(in_ready[u]), 32'd1);
  endtask

  task automatic wait_result(input int u, output int lat);
    lat = 0;
    while (out_valid[u] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Full transaction; returns with the result already consumed if out_ready is high.
  task automatic txn(input int u, input logic [12:0] x, input string tag);
    int lat, ey, ee, ec;
    wait_ready(u);
    in_x        = x;
    in_valid[u] = 1'b1;
    tick();
    in_valid[u] = 1'b0;
    wait_result(u, lat);
    model(thr_of[u], ee_of[u], x, ey, ee, ec);
    check({tag, "_latency"}, 32'(lat), 32'(ec));
    check({tag, "_y"},       32'(out_y[u]), 32'(ey));
    check({tag, "_early"},   32'(out_early[u]), 32'(ee));
    check({tag, "_chunks"},  32'(out_chunks[u]), 32'(ec));
    $display("txn u%0d x=%04h y=%0d early=%0d chunks=%0d lat=%0d", u, x,
             out_y[u], out_early[u], out_chunks[u], lat);
    if (out_ready[u] === 1'b1) begin
      tick();
      check({tag, "_consumed"}, 32'(out_valid[u]), 32'd0);
    end
  endtask

  initial begin
    int lat;
    int ey, ee, ec;
    logic [12:0] v;

    rst  = 1'b1;
    in_x = '0;
    for (int u = 0; u < 4; u++) begin
      in_valid[u]  = 1'b0;
      out_ready[u] = 1'b1;
    end
    tick(); tick(); tick();

    // Reset state
    check("rst_out_valid",  32'(out_valid[0]),  32'd0);
    check("rst_in_ready",   32'(in_ready[0]),   32'd1);
    check("rst_out_y",      32'(out_y[0]),      32'd0);
    check("rst_out_early",  32'(out_early[0]),  32'd0);
    check("rst_out_chunks", 32'(out_chunks[0]), 32'd0);
    rst = 1'b0;
    tick();

    // Early exit with defaults
    txn(0, 13'h1FFF, "ee_ones");
    check("ee_ones_chunks_dir", 32'(out_chunks[0]), 32'd2);
    txn(0, 13'h0000, "ee_zeros");
    check("ee_zeros_chunks_dir", 32'(out_chunks[0]), 32'd2);
    txn(0, 13'h003F, "ee_3f");
    check("ee_3f_chunks_dir", 32'(out_chunks[0]), 32'd4);

    // Backpressure
    out_ready[0] = 1'b0;
    wait_ready(0);
    in_x        = 13'h1FFF;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    wait_result(0, lat);
    check("bp_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid[0]), 32'd1);
      check("bp_hold_y",     32'(out_y[0]),     32'd1);
      check("bp_hold_ready", 32'(in_ready[0]),  32'd0);
    end
    out_ready[0] = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid[0]), 32'd0);
    check("bp_release_ready", 32'(in_ready[0]),  32'd1);

    // Reset in the middle of accumulation (no early exit)
    wait_ready(1);
    in_x        = 13'h1FFF;
    in_valid[1] = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid[1]), 32'd0);
    check("midrst_in_ready",  32'(in_ready[1]),  32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_no_result", 32'(out_valid[1]), 32'd0);
    end
    txn(1, 13'h0001, "midrst_next");

    // Threshold configurations
    txn(2, 13'h1000, "t1_msb");
    txn(2, 13'h0000, "t1_zero");
    txn(3, 13'h1FFE, "t13_miss");
    txn(3, 13'h1FFF, "t13_all");

    // Input isolation: in_valid held and in_x toggling while busy
    v = 13'($urandom_range(0, 8191));
    out_ready[0] = 1'b0;
    wait_ready(0);
    in_x        = v;
    in_valid[0] = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      in_x = 13'($urandom_range(0, 8191));
      check("iso_in_ready", 32'(in_ready[0]), 32'd0);
      tick();
    end
    model(7, 1, v, ey, ee, ec);
    check("iso_valid",  32'(out_valid[0]),  32'd1);
    check("iso_y",      32'(out_y[0]),      32'(ey));
    check("iso_early",  32'(out_early[0]),  32'(ee));
    check("iso_chunks", 32'(out_chunks[0]), 32'(ec));
    $display("txn u0 isolation x=%04h y=%0d chunks=%0d", v, out_y[0], out_chunks[0]);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    check("iso_consumed", 32'(out_valid[0]), 32'd0);

    // Random vectors against the reference model
    for (int i = 0; i < 300; i++) begin
      txn(0, 13'($urandom_range(0, 8191)), "rnd_ee1");
      txn(1, 13'($urandom_range(0, 8191)), "rnd_ee0");
    end
    for (int i = 0; i < 100; i++) begin
      txn(2, 13'($urandom_range(0, 8191)), "rnd_t1");
      txn(3, 13'($urandom_range(0, 8191)), "rnd_t13");
    end
    txn(1, 13'h1FFF, "ee0_ones");
    txn(1, 13'h0000, "ee0_zeros");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
